// File: rtl/cjb_arith_arbiter_v.sv
// Two-requester arbiter in front of the combinational cjb_8bit_arith_unit_v.
// Define CJB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module cjb_arith_arbiter_v (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [1:0] Func0,
    input  logic [1:0] Func1,
    input  logic [7:0] X0,
    input  logic [7:0] X1,
    input  logic [7:0] Y0,
    input  logic [7:0] Y1,
    input  logic [1:0] K0,
    input  logic [1:0] K1,
    output logic       Ack0,
    output logic       Ack1,
    output logic [1:0] Grant,
    output logic       Busy,
    output logic [7:0] Result,
    output logic [3:0] CNVZ,
    output logic [1:0] AU_Func_Sel,
    output logic [7:0] AU_Operand_X,
    output logic [7:0] AU_Operand_Y,
    output logic [1:0] AU_Const_K,
    input  logic [7:0] AU_Result,
    input  logic [3:0] AU_CNVZ
);
    localparam int unsigned DW  = 8;
    localparam int unsigned FW  = 2;
    localparam int unsigned KW  = 2;
    localparam int unsigned FLW = 4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state, state_nxt;
    logic            ack0_nxt, ack1_nxt, busy_nxt;
    logic [1:0]      grant_nxt;
    logic [DW-1:0]   result_nxt, au_x_nxt, au_y_nxt;
    logic [FLW-1:0]  cnvz_nxt;
    logic [FW-1:0]   au_func_nxt;
    logic [KW-1:0]   au_k_nxt;
    logic            pick1_c;

`ifdef CJB_ARB_FIXED_PRIO_EN
    assign pick1_c = Req1 & ~Req0;
`else
    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie
    logic last_grant, last_grant_nxt;
    assign pick1_c = Req1 & (~Req0 | ~last_grant);
`endif

    // Next-state and registered-output values
    always_comb begin
        state_nxt   = state;
        grant_nxt   = Grant;
        busy_nxt    = Busy;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        result_nxt  = Result;
        cnvz_nxt    = CNVZ;
        au_func_nxt = AU_Func_Sel;
        au_x_nxt    = AU_Operand_X;
        au_y_nxt    = AU_Operand_Y;
        au_k_nxt    = AU_Const_K;
`ifndef CJB_ARB_FIXED_PRIO_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_nxt   = EXEC;
                    busy_nxt    = 1'b1;
                    grant_nxt   = pick1_c ? 2'b10 : 2'b01;
                    au_func_nxt = pick1_c ? Func1 : Func0;
                    au_x_nxt    = pick1_c ? X1 : X0;
                    au_y_nxt    = pick1_c ? Y1 : Y0;
                    au_k_nxt    = pick1_c ? K1 : K0;
                end
            end
            EXEC: begin
                state_nxt  = DONE;
                result_nxt = AU_Result;
                cnvz_nxt   = AU_CNVZ;
                ack0_nxt   = Grant[0];
                ack1_nxt   = Grant[1];
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
                busy_nxt  = 1'b0;
`ifndef CJB_ARB_FIXED_PRIO_EN
                last_grant_nxt = Grant[1];
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            Grant        <= 2'b00;
            Busy         <= 1'b0;
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
            Result       <= '0;
            CNVZ         <= '0;
            AU_Func_Sel  <= '0;
            AU_Operand_X <= '0;
            AU_Operand_Y <= '0;
            AU_Const_K   <= '0;
`ifndef CJB_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            state        <= state_nxt;
            Grant        <= grant_nxt;
            Busy         <= busy_nxt;
            Ack0         <= ack0_nxt;
            Ack1         <= ack1_nxt;
            Result       <= result_nxt;
            CNVZ         <= cnvz_nxt;
            AU_Func_Sel  <= au_func_nxt;
            AU_Operand_X <= au_x_nxt;
            AU_Operand_Y <= au_y_nxt;
            AU_Const_K   <= au_k_nxt;
`ifndef CJB_ARB_FIXED_PRIO_EN
            last_grant   <= last_grant_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_cjb_arith_arbiter_v.sv
// Scoreboard bench for cjb_arith_arbiter_v with a behavioural arithmetic unit on the AU_* side.
module tb_cjb_arith_arbiter_v;
    logic       Clock = 1'b0;
    logic       Reset;
    logic       Req0, Req1;
    logic [1:0] Func0, Func1, K0, K1;
    logic [7:0] X0, X1, Y0, Y1;
    logic       Ack0, Ack1, Busy;
    logic [1:0] Grant, AU_Func_Sel, AU_Const_K;
    logic [7:0] Result, AU_Operand_X, AU_Operand_Y, AU_Result;
    logic [3:0] CNVZ, AU_CNVZ;

    typedef struct {
        int         id;
        logic [1:0] func;
        logic [7:0] x, y;
        logic [1:0] k;
        logic [7:0] res;
        logic [3:0] cnvz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_id  = 1;

    always #5 Clock = ~Clock;

    cjb_arith_arbiter_v dut (
        .Clock(Clock), .Reset(Reset), .Req0(Req0), .Req1(Req1),
        .Func0(Func0), .Func1(Func1), .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1),
        .K0(K0), .K1(K1), .Ack0(Ack0), .Ack1(Ack1), .Grant(Grant), .Busy(Busy),
        .Result(Result), .CNVZ(CNVZ), .AU_Func_Sel(AU_Func_Sel),
        .AU_Operand_X(AU_Operand_X), .AU_Operand_Y(AU_Operand_Y),
        .AU_Const_K(AU_Const_K), .AU_Result(AU_Result), .AU_CNVZ(AU_CNVZ)
    );

    // Arithmetic unit behaviour: returns {C,N,V,Z,result}
    function automatic logic [11:0] au_model(input logic [1:0] f, input logic [7:0] x,
                                             input logic [7:0] y, input logic [1:0] k);
        int a, b, s;
        logic [7:0] r;
        logic c, v;
        a = int'(x);
        b = f[1] ? int'(k) : int'(y);
        if (f[0]) begin
            s = a - b;
            c = (a >= b);
        end else begin
            s = a + b;
            c = (s > 255);
        end
        r = 8'(s);
        v = f[0] ? ((x[7] != b[7]) && (r[7] != x[7])) : ((x[7] == b[7]) && (r[7] != x[7]));
        return {c, r[7], v, (r == 8'h00), r};
    endfunction

    assign {AU_CNVZ, AU_Result} = au_model(AU_Func_Sel, AU_Operand_X, AU_Operand_Y, AU_Const_K);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic set_ops(input int id, input logic [1:0] f, input logic [7:0] x,
                           input logic [7:0] y, input logic [1:0] k);
        if (id == 0) begin Func0 = f; X0 = x; Y0 = y; K0 = k; end
        else         begin Func1 = f; X1 = x; Y1 = y; K1 = k; end
    endtask

    task automatic rand_ops(input int id);
        set_ops(id, 2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    endtask

    function automatic exp_t mk_exp(input int id);
        exp_t e;
        logic [11:0] m;
        e.id   = id;
        e.func = id ? Func1 : Func0;
        e.x    = id ? X1 : X0;
        e.y    = id ? Y1 : Y0;
        e.k    = id ? K1 : K0;
        m      = au_model(e.func, e.x, e.y, e.k);
        e.res  = m[7:0];
        e.cnvz = m[11:8];
        return e;
    endfunction

    function automatic int tie_winner();
`ifdef CJB_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last_id == 0) ? 1 : 0;
`endif
    endfunction

    // Raise the selected requests together; each drops on its Ack
    task automatic run_round(input bit u0, input bit u1);
        int first;
        first = (u0 && u1) ? tie_winner() : (u0 ? 0 : 1);
        exp_q.push_back(mk_exp(first));
        last_id = first;
        if (u0 && u1) begin
            exp_q.push_back(mk_exp(1 - first));
            last_id = 1 - first;
        end
        Req0 = u0; Req1 = u1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (Ack0) Req0 = 1'b0;
            if (Ack1) Req1 = 1'b0;
            if (!Req0 && !Req1) break;
        end
        if (Req0 || Req1) begin
            fail_now("round_ack_wait");
            Req0 = 1'b0; Req1 = 1'b0;
        end
        @(posedge Clock); #1;
    endtask

    // Both requests held continuously for n completed operations
    task automatic held_both(input int n);
        int w, acks;
        w = last_id;
        for (int i = 0; i < n; i++) begin
            w = tie_winner();
            exp_q.push_back(mk_exp(w));
            last_id = w;
        end
        acks = 0;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int i = 0; i < 8 * n; i++) begin
            @(posedge Clock); #1;
            if (Ack0 || Ack1) acks++;
            if (acks == n) break;
        end
        if (acks != n) fail_now("held_both_ack_wait");
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clock); #1;
    endtask

    // Req0 held through its first Ack, giving a second identical operation
    task automatic held_twice();
        int acks;
        exp_q.push_back(mk_exp(0));
        exp_q.push_back(mk_exp(0));
        last_id = 0;
        acks = 0;
        Req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (Ack0) acks++;
            if (acks == 2) break;
        end
        if (acks != 2) fail_now("held_twice_ack_wait");
        Req0 = 1'b0;
        @(posedge Clock); #1;
    endtask

    // Monitor: EXEC operands/grant, Ack payload, Ack exclusivity, Ack timing
    bit ack_due = 1'b0;
    always @(negedge Clock) begin
        if (Reset) begin
            ack_due = 1'b0;
        end else begin
            if (Ack0 && Ack1) chk("ack_exclusive", {Ack0, Ack1}, 2'b00);
            if (ack_due) chk("ack_after_exec", 32'(Ack0 | Ack1), 1);
            ack_due = 1'b0;
            if (Ack0 || Ack1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {Ack1, Ack0}, 2'b00);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_id",  32'(Ack1), 32'(e.id));
                    chk("ack_grant", Grant, (e.id != 0) ? 2'b10 : 2'b01);
                    chk("ack_busy", 32'(Busy), 1);
                    chk("result", Result, e.res);
                    chk("cnvz", CNVZ, e.cnvz);
                end
            end else if (Busy) begin
                ack_due = 1'b1;
                if (exp_q.size() != 0) begin
                    chk("exec_grant", Grant, (exp_q[0].id != 0) ? 2'b10 : 2'b01);
                    chk("exec_au_ops", {AU_Func_Sel, AU_Operand_X, AU_Operand_Y, AU_Const_K},
                        {exp_q[0].func, exp_q[0].x, exp_q[0].y, exp_q[0].k});
                end else begin
                    chk("exec_without_request", 32'(Busy), 0);
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string name);
        chk(name, {Ack0, Ack1, Grant, Busy, Result, CNVZ}, '0);
    endtask

    initial begin
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        set_ops(0, 2'd0, 8'd0, 8'd0, 2'd0);
        set_ops(1, 2'd0, 8'd0, 8'd0, 2'd0);
        #1;
        chk_zero_outputs("reset_outputs");
        chk("reset_au_regs", {AU_Func_Sel, AU_Operand_X, AU_Operand_Y, AU_Const_K}, '0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(posedge Clock); #1;

        // Directed cases
        set_ops(0, 2'b00, 8'h7F, 8'h01, 2'd0);
        run_round(1'b1, 1'b0);
        chk("t1_result", {Result, CNVZ}, {8'h80, 4'b0110});
        set_ops(1, 2'b01, 8'h05, 8'h05, 2'd0);
        run_round(1'b0, 1'b1);
        chk("t2_result", {Result, CNVZ}, {8'h00, 4'b1001});
        set_ops(1, 2'b10, 8'hFF, 8'h33, 2'd1);
        run_round(1'b0, 1'b1);
        set_ops(1, 2'b11, 8'h00, 8'h77, 2'd2);
        run_round(1'b0, 1'b1);
        chk("t3_result", {Result, CNVZ}, {8'hFE, 4'b0100});

        // Tie-break with continuously held requests
        rand_ops(0); rand_ops(1);
        held_both(4);

        // Reset pulsed during EXEC discards the pending op
        set_ops(0, 2'b00, 8'h10, 8'h20, 2'd0);
        exp_q.push_back(mk_exp(0));
        Req0 = 1'b1;
        @(posedge Clock); #1;
        Req0 = 1'b0;
        #2 Reset = 1'b1;
        exp_q.delete();
        last_id = 1;
        #1 chk_zero_outputs("reset_in_exec");
        @(posedge Clock); #1 Reset = 1'b0;
        repeat (4) @(posedge Clock);
        #1 chk_zero_outputs("idle_after_reset");
        set_ops(0, 2'b00, 8'h01, 8'h01, 2'd0);
        run_round(1'b1, 1'b0);
        chk("t5_result", {Result, CNVZ}, {8'h02, 4'b0000});

        // Req0 dropped during EXEC still completes once
        set_ops(0, 2'b01, 8'h80, 8'h01, 2'd0);
        exp_q.push_back(mk_exp(0));
        last_id = 0;
        Req0 = 1'b1;
        @(posedge Clock); #1 Req0 = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        chk("drop_ack_seen", 32'(exp_q.size()), 0);
        held_twice();

        // Randomized rounds
        for (int i = 0; i < 60; i++) begin
            int u;
            u = int'($urandom_range(1, 3));
            rand_ops(0); rand_ops(1);
            run_round(u[0], u[1]);
        end
        rand_ops(0); rand_ops(1);
        held_both(5);

        repeat (3) @(posedge Clock);
        #1 chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
